// File: rtl/alu_sequencer.sv
// Multi-cycle ALU issue sequencer: reads operands from a local register file,
// drives the ALU, captures result/flags and writes the result back.
module alu_sequencer #(
    parameter int unsigned NREGS = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic          instr_mode,
    input  logic [AW-1:0] instr_rs,
    input  logic [AW-1:0] instr_rt,
    input  logic [AW-1:0] instr_rd,
    input  logic          instr_wide,
    input  logic          load_valid,
    input  logic [AW-1:0] load_addr,
    input  logic [15:0]   load_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [15:0]   dbg_data,
    output logic [15:0]   alu_a,
    output logic [15:0]   alu_b,
    output logic [2:0]    alu_opcode,
    output logic          alu_mode,
    input  logic [31:0]   alu_out,
    input  logic          alu_za,
    input  logic          alu_zb,
    input  logic          alu_eq,
    input  logic          alu_gt,
    input  logic          alu_lt,
    output logic [4:0]    flags_q,
    output logic [31:0]   result_q,
    output logic          busy,
    output logic          done
);

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        OPER = 3'd1,
        EXEC = 3'd2,
        WBLO = 3'd3,
        WBHI = 3'd4
    } state_t;

    state_t        state, state_next;
    logic [DW-1:0] rf [NREGS];

    logic [2:0]    op_q;
    logic          mode_q;
    logic [AW-1:0] rs_q, rt_q, rd_q;
    logic          wide_q;

    logic          accept_c;
    logic          finish_c;
    logic [AW-1:0] rd_hi_c;

    assign dbg_data = rf[dbg_addr];
    assign rd_hi_c  = AW'(rd_q + AW'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and handshake decode
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        finish_c   = 1'b0;
        case (state)
            IDLE: begin
                if (instr_valid && instr_ready) begin
                    accept_c   = 1'b1;
                    state_next = OPER;
                end
            end
            OPER: state_next = EXEC;
            EXEC: state_next = WBLO;
            WBLO: begin
                if (wide_q) begin
                    state_next = WBHI;
                end else begin
                    state_next = IDLE;
                    finish_c   = 1'b1;
                end
            end
            WBHI: begin
                state_next = IDLE;
                finish_c   = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered status outputs track the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            instr_ready <= (state_next == IDLE);
            busy        <= (state_next != IDLE);
            done        <= finish_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            mode_q <= 1'b0;
            rs_q   <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
            wide_q <= 1'b0;
        end else if (accept_c) begin
            op_q   <= instr_op;
            mode_q <= instr_mode;
            rs_q   <= instr_rs;
            rt_q   <= instr_rt;
            rd_q   <= instr_rd;
            wide_q <= instr_wide;
        end
    end

    // ALU drive registers hold until the next operand fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            alu_mode   <= 1'b0;
        end else if (state == OPER) begin
            alu_a      <= rf[rs_q];
            alu_b      <= rf[rt_q];
            alu_opcode <= op_q;
            alu_mode   <= mode_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
        end else if (state == EXEC) begin
            result_q <= RW'(alu_out);
            flags_q  <= {alu_za, alu_zb, alu_eq, alu_gt, alu_lt};
        end
    end

    // Host loads only land in IDLE; writeback owns the file otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            case (state)
                IDLE: if (load_valid) rf[load_addr] <= load_data;
                WBLO: rf[rd_q]    <= result_q[DW-1:0];
                WBHI: rf[rd_hi_c] <= result_q[RW-1:DW];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU model
// ({b,a} result, compare flags) and hand-computed expectations.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, instr_ready;
    logic [2:0]  instr_op;
    logic        instr_mode;
    logic [2:0]  instr_rs, instr_rt, instr_rd;
    logic        instr_wide;
    logic        load_valid;
    logic [2:0]  load_addr;
    logic [15:0] load_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_opcode;
    logic        alu_mode;
    logic [31:0] alu_out;
    logic        alu_za, alu_zb, alu_eq, alu_gt, alu_lt;
    logic [4:0]  flags_q;
    logic [31:0] result_q;
    logic        busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign alu_out = {alu_b, alu_a};
    assign alu_za  = (alu_a == 16'h0);
    assign alu_zb  = (alu_b == 16'h0);
    assign alu_eq  = (alu_a == alu_b);
    assign alu_gt  = (alu_a > alu_b);
    assign alu_lt  = (alu_a < alu_b);

    alu_sequencer #(.NREGS(8), .AW(3)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_mode(instr_mode),
        .instr_rs(instr_rs), .instr_rt(instr_rt), .instr_rd(instr_rd),
        .instr_wide(instr_wide),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_mode(alu_mode),
        .alu_out(alu_out),
        .alu_za(alu_za), .alu_zb(alu_zb), .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_lt(alu_lt),
        .flags_q(flags_q), .result_q(result_q), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic rf_check(input string tag, input logic [2:0] addr, input logic [15:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, 32'(dbg_data), 32'(exp));
    endtask

    task automatic load(input logic [2:0] addr, input logic [15:0] data);
        load_valid = 1'b1;
        load_addr  = addr;
        load_data  = data;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic set_instr(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                             input logic [2:0] op, input logic mode, input logic wide);
        instr_rs   = rs;
        instr_rt   = rt;
        instr_rd   = rd;
        instr_op   = op;
        instr_mode = mode;
        instr_wide = wide;
    endtask

    // Offer from IDLE, return in cycle 1 (after the accept edge)
    task automatic issue(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                         input logic [2:0] op, input logic mode, input logic wide);
        set_instr(rs, rt, rd, op, mode, wide);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, output int cyc);
        cyc = start;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc;
    int k;
    int acc [3];
    logic saw_done;

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        set_instr(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        load_valid = 1'b0; load_addr = '0; load_data = '0;
        dbg_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("init_ready", 32'(instr_ready), 32'd1);
        check("init_busy", 32'(busy), 32'd0);

        // Reset mid-instruction
        load(3'd1, 16'h1111);
        issue(3'd1, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1);
        @(negedge clk);
        check("pre_rst_alu_a", 32'(alu_a), 32'h1111);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_alu_a", 32'(alu_a), 32'h0);
        check("rst_alu_b", 32'(alu_b), 32'h0);
        check("rst_opc_mode", 32'({alu_opcode, alu_mode}), 32'h0);
        check("rst_flags", 32'(flags_q), 32'h0);
        check("rst_result", 32'(result_q), 32'h0);
        check("rst_busy_done", 32'({busy, done}), 32'h0);
        for (int a = 0; a < 8; a++) rf_check("rst_rf", 3'(a), 16'h0);
        rst = 1'b0;
        saw_done = 1'b0;
        @(negedge clk);
        check("rst_ready_next", 32'(instr_ready), 32'd1);
        repeat (6) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("rst_no_done", 32'(saw_done), 32'd0);
        rf_check("rst_no_wb_r2", 3'd2, 16'h0);
        rf_check("rst_no_wb_r3", 3'd3, 16'h0);

        // Non-wide logic op
        load(3'd1, 16'h1234);
        load(3'd2, 16'h00FF);
        issue(3'd1, 3'd2, 3'd3, 3'd5, 1'b1, 1'b0);
        @(negedge clk);
        check("nw_opcode", 32'(alu_opcode), 32'd5);
        check("nw_mode", 32'(alu_mode), 32'd1);
        check("nw_alu_a", 32'(alu_a), 32'h1234);
        check("nw_alu_b", 32'(alu_b), 32'h00FF);
        check("nw_done_early", 32'(done), 32'd0);
        wait_done(2, cyc);
        check("nw_latency", 32'(cyc), 32'd4);
        check("nw_result", result_q, 32'h00FF_1234);
        check("nw_flags", 32'(flags_q), 32'b00010);
        rf_check("nw_r3", 3'd3, 16'h1234);
        rf_check("nw_r4", 3'd4, 16'h0);
        @(negedge clk);
        check("nw_done_pulse", 32'(done), 32'd0);

        // Wide op wrapping into r0
        load(3'd5, 16'hAAAA);
        load(3'd6, 16'h5555);
        issue(3'd5, 3'd6, 3'd7, 3'd0, 1'b0, 1'b1);
        wait_done(1, cyc);
        check("wide_latency", 32'(cyc), 32'd5);
        rf_check("wide_r7", 3'd7, 16'hAAAA);
        rf_check("wide_r0", 3'd0, 16'h5555);
        @(negedge clk);
        check("wide_done_pulse", 32'(done), 32'd0);

        // Self-overwrite
        load(3'd2, 16'h0007);
        issue(3'd2, 3'd2, 3'd2, 3'd1, 1'b0, 1'b0);
        @(negedge clk);
        check("self_alu_a", 32'(alu_a), 32'h7);
        check("self_alu_b", 32'(alu_b), 32'h7);
        wait_done(2, cyc);
        check("self_latency", 32'(cyc), 32'd4);
        check("self_flags", 32'(flags_q), 32'b00100);
        rf_check("self_r2", 3'd2, 16'h0007);
        @(negedge clk);

        // Back-to-back with held valid; busy-time loads to r6 must be dropped
        k = 0;
        cyc = 0;
        set_instr(3'd0, 3'd1, 3'd4, 3'd0, 1'b0, 1'b0);
        instr_valid = 1'b1;
        load_addr = 3'd6;
        load_data = 16'hDEAD;
        while (k < 3 && cyc < 60) begin
            load_valid = ~instr_ready;
            if (instr_ready) begin
                acc[k] = cyc;
                if (k > 0) check("b2b_done_at_accept", 32'(done), 32'd1);
                k++;
                @(negedge clk);
                cyc++;
                if (k == 1)      set_instr(3'd4, 3'd2, 3'd3, 3'd0, 1'b0, 1'b0);
                else if (k == 2) set_instr(3'd6, 3'd5, 3'd4, 3'd0, 1'b0, 1'b0);
                else             instr_valid = 1'b0;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        load_valid = 1'b0;
        instr_valid = 1'b0;
        check("b2b_accepted", 32'(k), 32'd3);
        check("b2b_rate01", 32'(acc[1] - acc[0]), 32'd4);
        check("b2b_rate12", 32'(acc[2] - acc[1]), 32'd4);
        wait_done(1, cyc);
        check("b2b_last_latency", 32'(cyc), 32'd4);
        rf_check("b2b_r3", 3'd3, 16'h5555);
        rf_check("b2b_r4", 3'd4, 16'h5555);
        rf_check("b2b_r6", 3'd6, 16'h5555);
        @(negedge clk);

        // Same-edge load and accept
        load_valid = 1'b1;
        load_addr = 3'd1;
        load_data = 16'hBEEF;
        issue(3'd1, 3'd0, 3'd4, 3'd2, 1'b0, 1'b0);
        load_valid = 1'b0;
        @(negedge clk);
        check("same_alu_a", 32'(alu_a), 32'hBEEF);
        wait_done(2, cyc);
        check("same_latency", 32'(cyc), 32'd4);
        rf_check("same_r4", 3'd4, 16'hBEEF);
        rf_check("same_r1", 3'd1, 16'hBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
